sw_host: RTL
============

SW_HOST -- requirements
Module: sw_host

Interface
REQ-001 The block SHALL provide parameter HOLD_CYCLES, default 4: number of cycles Handshake (SwOut[8]) is held high, and then low, per operand (legal range 1..255).
REQ-002 The block SHALL provide parameter OPS_PER_RESULT, default 2: number of operands sent before one result is captured (legal range 1..15).
REQ-003 The block SHALL provide parameter RESULT_WAIT, default 16: number of cycles from the final handshake-low phase ending to the result sample (legal range 1..255).
REQ-004 Clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 nReset  input  1  asynchronous active-low reset.
REQ-006 OpData  input  8  operand offered by the upstream source.
REQ-007 OpValid  input  1  OpData is valid.
REQ-008 OpReady  output  1  the block accepts OpData this cycle; transfer occurs when OpValid and OpReady are both high.
REQ-009 SwOut  output  10  drives the processor switch bus: [9] processor run/reset-release, [8] Handshake, [7:0] operand.
REQ-010 LedIn  input  8  processor LED (accumulator) bus.
REQ-011 Result  output  8  captured LedIn value.
REQ-012 ResultValid  output  1  single-cycle pulse; Result is valid in that cycle.
REQ-013 Busy  output  1  high in every state except IDLE.

Function
REQ-014 The block SHALL implement the states IDLE, RELEASE, WAIT_OP, HS_HIGH, HS_LOW, SETTLE and CAPTURE.
REQ-015 RELEASE SHALL hold SwOut[9]=0 for 2 cycles, then set SwOut[9]=1 and enter WAIT_OP; SwOut[9] SHALL then stay 1 until the next reset.
REQ-016 The block SHALL leave IDLE for RELEASE on the first clock edge after reset deasserts.
REQ-017 OpReady SHALL be high only in WAIT_OP, and an accepted operand SHALL be registered onto SwOut[7:0] with a transition to HS_HIGH.
REQ-018 HS_HIGH SHALL drive SwOut[8]=1 for exactly HOLD_CYCLES cycles, then enter HS_LOW.
REQ-019 HS_LOW SHALL drive SwOut[8]=0 for exactly HOLD_CYCLES cycles.
REQ-020 SwOut[7:0] SHALL stay stable from acceptance through the end of HS_LOW.
REQ-021 The block SHALL maintain a 4-bit operand counter that increments at the end of each HS_LOW.
REQ-022 At the end of HS_LOW, if the counter has reached OPS_PER_RESULT, the block SHALL clear the counter and enter SETTLE; otherwise it SHALL return to WAIT_OP.
REQ-023 SETTLE SHALL last exactly RESULT_WAIT cycles, then enter CAPTURE.
REQ-024 CAPTURE SHALL last one cycle: Result<=LedIn and ResultValid=1, then return to WAIT_OP.
REQ-025 The handshake counter SHALL be 8 bits and reload on every state entry, with no wrap-around within a phase.
REQ-026 OpValid SHALL be ignored outside WAIT_OP; an operand offered during SETTLE/CAPTURE SHALL be accepted only in the first WAIT_OP cycle.
REQ-027 Minimum operand period SHALL be 2*HOLD_CYCLES+1 cycles.

Reset
REQ-028 Asserting nReset at any time, including mid-handshake, SHALL immediately force: state IDLE, SwOut=10'h000, OpReady=0, Result=8'h00, ResultValid=0, Busy=0, all counters 0; no partial result is emitted.

Configuration
REQ-029 With macro SW_HOST_STABLE_CHECK_EN defined, the block SHALL add output Unstable (1 bit, reset 0) and also sample LedIn in the last SETTLE cycle; Unstable SHALL pulse with ResultValid when that sample differs from the CAPTURE sample.
REQ-030 Without SW_HOST_STABLE_CHECK_EN, port Unstable and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-031 Reset release: deassert nReset -> SwOut[9]=0 for 2 cycles, then 1; OpReady rises the next cycle.
REQ-032 Defaults, operands 8'h05 then 8'hFB: each produces SwOut[8] high 4 cycles, then low 4 cycles, with SwOut[7:0] stable; ResultValid pulses 16 cycles after the second low phase ends, with Result equal to LedIn (drive 8'h3C -> Result=8'h3C).
REQ-033 OpValid held continuously: accepted operands are exactly 9 cycles apart; OpReady is 0 during SETTLE and CAPTURE.
REQ-034 nReset pulsed during the third HS_HIGH cycle: SwOut=0 immediately, no ResultValid, and the operand count restarts so two fresh operands are required for the next result.
REQ-035 HOLD_CYCLES=1, OPS_PER_RESULT=1, RESULT_WAIT=1: operand 8'h80 -> one high cycle, one low cycle, one SETTLE cycle, then ResultValid.
REQ-036 With SW_HOST_STABLE_CHECK_EN, LedIn changes 8'h10->8'h11 at the CAPTURE edge -> Result=8'h11, Unstable=1 for one cycle; with LedIn held constant, Unstable stays 0.

Source files
------------

// File: rtl/sw_host.sv
// sw_host: feeds operands onto a processor switch bus with a timed handshake, samples LedIn after every OPS_PER_RESULT operands.
// Optional SW_HOST_STABLE_CHECK_EN adds Unstable: LedIn differed between the last SETTLE cycle and CAPTURE.
module sw_host #(
  parameter int HOLD_CYCLES    = 4,
  parameter int OPS_PER_RESULT = 2,
  parameter int RESULT_WAIT    = 16
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [7:0] OpData,
  input  logic       OpValid,
  output logic       OpReady,
  output logic [9:0] SwOut,
  input  logic [7:0] LedIn,
  output logic [7:0] Result,
  output logic       ResultValid,
`ifdef SW_HOST_STABLE_CHECK_EN
  output logic       Unstable,
`endif
  output logic       Busy
);

  typedef enum logic [2:0] {
    IDLE,
    RELEASE,
    WAIT_OP,
    HS_HIGH,
    HS_LOW,
    SETTLE,
    CAPTURE
  } state_t;

  // Phase counters hold "cycles remaining minus one" so a phase of N cycles ends when the counter reads zero.
  localparam logic [7:0] REL_LOAD  = 8'd1;
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] WAIT_LOAD = 8'(RESULT_WAIT - 1);
  localparam logic [3:0] OPS_LAST  = 4'(OPS_PER_RESULT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] hcnt;
  logic [7:0] hcnt_nxt;
  logic [3:0] opcnt;
  logic [3:0] opcnt_nxt;
  logic [3:0] opcnt_inc;
  logic [7:0] data_q;
  logic       run_q;
  logic       accept;
  logic       phase_end;

  assign opcnt_inc = opcnt + 4'd1;
  assign phase_end = (hcnt == 8'd0);

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    opcnt_nxt = opcnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = RELEASE;
        hcnt_nxt  = REL_LOAD;
      end
      RELEASE: begin
        if (phase_end) begin
          state_nxt = WAIT_OP;
          hcnt_nxt  = 8'd0;
        end else begin
          hcnt_nxt = hcnt - 8'd1;
        end
      end
      WAIT_OP: begin
        if (OpValid) begin
          accept    = 1'b1;
          state_nxt = HS_HIGH;
          hcnt_nxt  = HOLD_LOAD;
        end
      end
      HS_HIGH: begin
        if (phase_end) begin
          state_nxt = HS_LOW;
          hcnt_nxt  = HOLD_LOAD;
        end else begin
          hcnt_nxt = hcnt - 8'd1;
        end
      end
      HS_LOW: begin
        if (phase_end) begin
          if (opcnt_inc == OPS_LAST) begin
            opcnt_nxt = 4'd0;
            state_nxt = SETTLE;
            hcnt_nxt  = WAIT_LOAD;
          end else begin
            opcnt_nxt = opcnt_inc;
            state_nxt = WAIT_OP;
            hcnt_nxt  = 8'd0;
          end
        end else begin
          hcnt_nxt = hcnt - 8'd1;
        end
      end
      SETTLE: begin
        if (phase_end) begin
          state_nxt = CAPTURE;
          hcnt_nxt  = 8'd0;
        end else begin
          hcnt_nxt = hcnt - 8'd1;
        end
      end
      CAPTURE: begin
        state_nxt = WAIT_OP;
        hcnt_nxt  = 8'd0;
      end
      default: begin
        state_nxt = IDLE;
        hcnt_nxt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      hcnt        <= 8'd0;
      opcnt       <= 4'd0;
      data_q      <= 8'h00;
      run_q       <= 1'b0;
      Result      <= 8'h00;
      ResultValid <= 1'b0;
    end else begin
      state       <= state_nxt;
      hcnt        <= hcnt_nxt;
      opcnt       <= opcnt_nxt;
      ResultValid <= (state == CAPTURE);
      if (accept) begin
        data_q <= OpData;
      end
      // Run bit rises with the RELEASE -> WAIT_OP transition and only reset clears it.
      if (state == RELEASE && phase_end) begin
        run_q <= 1'b1;
      end
      if (state == CAPTURE) begin
        Result <= LedIn;
      end
    end
  end

`ifdef SW_HOST_STABLE_CHECK_EN
  logic [7:0] settle_q;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      settle_q <= 8'h00;
      Unstable <= 1'b0;
    end else begin
      if (state == SETTLE && phase_end) begin
        settle_q <= LedIn;
      end
      Unstable <= (state == CAPTURE) && (LedIn != settle_q);
    end
  end
`endif

  assign OpReady = (state == WAIT_OP);
  assign Busy    = (state != IDLE);
  assign SwOut   = {run_q, (state == HS_HIGH), data_q};

endmodule
